// File: rtl/sa_sequencer.sv
// sa_sequencer: multi-tile controller for the sparse systolic array.
// Per tile: array reset, signal ROM fetch, weight LOAD phase, feature COMPUTE phase.
// Optional build macro SA_SEQ_STALL_EN adds stall_i back-pressure for LOAD/COMPUTE.
module sa_sequencer #(
    parameter int unsigned N_ROWS_ARRAY        = 4,
    parameter int unsigned N_COLS_ARRAY        = 4,
    parameter int unsigned N                   = 3,
    parameter int unsigned SEL_WIDTH           = $clog2(N),
    parameter int unsigned NUM_COL_WIDTH       = $clog2(N + 1),
    parameter int unsigned ROM_SIG_WIDTH       = 100,
    parameter int unsigned SIG_ADDRS_WIDTH     = 10,
    parameter int unsigned FEATURE_ADDRS_WIDTH = 10,
    parameter int unsigned WEIGHT_ADDRS_WIDTH  = 10,
    parameter int unsigned CNT_WIDTH           = 16
) (
    input  logic                                    clk_i,
    input  logic                                    general_rst_ni,
    input  logic                                    start_i,
    input  logic [NUM_COL_WIDTH-1:0]                filter_size_i,
    input  logic [CNT_WIDTH-1:0]                    n_tiles_i,
    input  logic [CNT_WIDTH-1:0]                    n_weights_i,
    input  logic [CNT_WIDTH-1:0]                    n_features_i,
`ifdef SA_SEQ_STALL_EN
    input  logic                                    stall_i,
`endif
    input  logic [ROM_SIG_WIDTH-1:0]                rom_signals_data_i,
    output logic                                    ready_o,
    output logic                                    done_o,
    output logic                                    rst_o,
    output logic                                    load_o,
    output logic                                    start_op_o,
    output logic                                    rd_rom_signals_ld_o,
    output logic [SIG_ADDRS_WIDTH-1:0]              addrs_rom_signal_o,
    output logic                                    rd_weight_ld_o,
    output logic [WEIGHT_ADDRS_WIDTH-1:0]           addrs_weight_o,
    output logic                                    rd_feature_ld_o,
    output logic [FEATURE_ADDRS_WIDTH-1:0]          addrs_mem_feature_o,
    output logic [N_ROWS_ARRAY*SEL_WIDTH-1:0]       f_sel_o,
    output logic [N_ROWS_ARRAY*NUM_COL_WIDTH-1:0]   number_of_columns_o,
    output logic [N_ROWS_ARRAY*NUM_COL_WIDTH-1:0]   row_num_o,
    output logic [N_COLS_ARRAY-1:0]                 en_adder_node_o
);

    localparam int unsigned FSEL_W = N_ROWS_ARRAY * SEL_WIDTH;
    localparam int unsigned NCOL_W = N_ROWS_ARRAY * NUM_COL_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARST,
        S_FETCH,
        S_SWAIT,
        S_LOAD,
        S_COMPUTE,
        S_DONE
    } state_e;

    state_e                         state_q, state_d;
    logic [NUM_COL_WIDTH-1:0]       fs_q, fs_d;
    logic [CNT_WIDTH-1:0]           ntiles_q, ntiles_d;
    logic [CNT_WIDTH-1:0]           nw_q, nw_d;
    logic [CNT_WIDTH-1:0]           nf_q, nf_d;
    logic [CNT_WIDTH-1:0]           tile_q, tile_d;
    logic [CNT_WIDTH-1:0]           cnt_q, cnt_d;
    logic [WEIGHT_ADDRS_WIDTH-1:0]  waddr_q, waddr_d;
    logic [FEATURE_ADDRS_WIDTH-1:0] faddr_q, faddr_d;
    logic [FSEL_W-1:0]              fsel_q, fsel_d;
    logic [NCOL_W-1:0]              ncol_q, ncol_d;
    logic [NCOL_W-1:0]              rownum_q, rownum_d;
    logic [N_COLS_ARRAY-1:0]        en_q, en_d;
    logic                           ready_q, ready_d;
    logic                           done_q, done_d;
    logic                           rst_q, rst_d;
    logic                           rd_rom_q, rd_rom_d;
    logic                           load_q, load_d;
    logic                           sop_q, sop_d;

    logic                           stall_c;
    logic                           skip_c;
    logic                           last_c;
    logic [NUM_COL_WIDTH-1:0]       col0_c;
    logic [NUM_COL_WIDTH-1:0]       rn_idx_c;
    logic [NCOL_W-1:0]              row_num_c;
    logic                           unused_rom_c;

    // Back-pressure only freezes the two streaming phases
`ifdef SA_SEQ_STALL_EN
    assign stall_c = stall_i && ((state_q == S_LOAD) || (state_q == S_COMPUTE));
`else
    assign stall_c = 1'b0;
`endif

    assign col0_c       = rom_signals_data_i[FSEL_W +: NUM_COL_WIDTH];
    assign unused_rom_c = ^rom_signals_data_i;

    // Per-row index pattern 1..filter_size repeating down the rows
    always_comb begin
        rn_idx_c  = NUM_COL_WIDTH'(1);
        row_num_c = '0;
        for (int unsigned j = 0; j < N_ROWS_ARRAY; j++) begin
            row_num_c[j*NUM_COL_WIDTH +: NUM_COL_WIDTH] = rn_idx_c;
            rn_idx_c = (rn_idx_c == fs_q) ? NUM_COL_WIDTH'(1) : rn_idx_c + NUM_COL_WIDTH'(1);
        end
    end

    // Next-state, counter/address and registered-output logic
    always_comb begin
        state_d  = state_q;
        fs_d     = fs_q;
        ntiles_d = ntiles_q;
        nw_d     = nw_q;
        nf_d     = nf_q;
        tile_d   = tile_q;
        cnt_d    = cnt_q;
        waddr_d  = waddr_q;
        faddr_d  = faddr_q;
        fsel_d   = fsel_q;
        ncol_d   = ncol_q;
        rownum_d = rownum_q;
        en_d     = en_q;
        skip_c   = 1'b0;
        last_c   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if ((filter_size_i == '0) || (n_tiles_i == '0)) begin
                        skip_c = 1'b1;
                    end else begin
                        fs_d     = filter_size_i;
                        ntiles_d = n_tiles_i;
                        nw_d     = n_weights_i;
                        nf_d     = n_features_i;
                        tile_d   = '0;
                        waddr_d  = '0;
                        state_d  = S_ARST;
                    end
                end
            end
            S_ARST: begin
                rownum_d = row_num_c;
                state_d  = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_SWAIT;
            end
            S_SWAIT: begin
                fsel_d = rom_signals_data_i[FSEL_W-1:0];
                ncol_d = rom_signals_data_i[FSEL_W +: NCOL_W];
                for (int unsigned c = 0; c < N_COLS_ARRAY; c++) begin
                    en_d[c] = (c < 32'(col0_c));
                end
                cnt_d   = '0;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (!stall_c) begin
                    if (nw_q != '0) begin
                        waddr_d = waddr_q + WEIGHT_ADDRS_WIDTH'(1);
                    end
                    last_c = (nw_q == '0) || (cnt_q == nw_q - CNT_WIDTH'(1));
                    if (last_c) begin
                        cnt_d   = '0;
                        faddr_d = '0;
                        state_d = S_COMPUTE;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            S_COMPUTE: begin
                if (!stall_c) begin
                    if (nf_q != '0) begin
                        faddr_d = faddr_q + FEATURE_ADDRS_WIDTH'(1);
                    end
                    last_c = (nf_q == '0) || (cnt_q == nf_q - CNT_WIDTH'(1));
                    if (last_c) begin
                        cnt_d = '0;
                        if (tile_q == ntiles_q - CNT_WIDTH'(1)) begin
                            state_d = S_DONE;
                        end else begin
                            tile_d  = tile_q + CNT_WIDTH'(1);
                            state_d = S_ARST;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d  = (state_d == S_IDLE);
        done_d   = (state_d == S_DONE) || skip_c;
        rst_d    = (state_d == S_ARST);
        rd_rom_d = (state_d == S_FETCH);
        load_d   = (state_d == S_LOAD) && (nw_q != '0);
        sop_d    = (state_d == S_COMPUTE) && (nf_q != '0);
    end

    // State, configuration, counters and output registers
    always_ff @(posedge clk_i or negedge general_rst_ni) begin
        if (!general_rst_ni) begin
            state_q  <= S_IDLE;
            fs_q     <= '0;
            ntiles_q <= '0;
            nw_q     <= '0;
            nf_q     <= '0;
            tile_q   <= '0;
            cnt_q    <= '0;
            waddr_q  <= '0;
            faddr_q  <= '0;
            fsel_q   <= '0;
            ncol_q   <= '0;
            rownum_q <= '0;
            en_q     <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            rst_q    <= 1'b0;
            rd_rom_q <= 1'b0;
            load_q   <= 1'b0;
            sop_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            fs_q     <= fs_d;
            ntiles_q <= ntiles_d;
            nw_q     <= nw_d;
            nf_q     <= nf_d;
            tile_q   <= tile_d;
            cnt_q    <= cnt_d;
            waddr_q  <= waddr_d;
            faddr_q  <= faddr_d;
            fsel_q   <= fsel_d;
            ncol_q   <= ncol_d;
            rownum_q <= rownum_d;
            en_q     <= en_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            rst_q    <= rst_d;
            rd_rom_q <= rd_rom_d;
            load_q   <= load_d;
            sop_q    <= sop_d;
        end
    end

    assign ready_o             = ready_q;
    assign done_o              = done_q;
    assign rst_o               = rst_q;
    assign load_o              = load_q;
    assign start_op_o          = sop_q;
    assign rd_rom_signals_ld_o = rd_rom_q;
    assign addrs_rom_signal_o  = SIG_ADDRS_WIDTH'(tile_q);
    assign rd_weight_ld_o      = load_q & ~stall_c;
    assign addrs_weight_o      = waddr_q;
    assign rd_feature_ld_o     = sop_q & ~stall_c;
    assign addrs_mem_feature_o = faddr_q;
    assign f_sel_o             = fsel_q;
    assign number_of_columns_o = ncol_q;
    assign row_num_o           = rownum_q;
    assign en_adder_node_o     = en_q;

endmodule

// File: tb/tb_sa_sequencer.sv
// Self-checking bench for sa_sequencer: per-cycle timeline model plus literal pins.
module tb_sa_sequencer;

    localparam int NR  = 4;
    localparam int NC  = 4;
    localparam int SW  = 2;
    localparam int CW  = 2;
    localparam int RW  = 100;
    localparam int AW  = 10;
    localparam int CNT = 16;

    logic              clk;
    logic              general_rst_ni;
    logic              start_i;
    logic [CW-1:0]     filter_size_i;
    logic [CNT-1:0]    n_tiles_i, n_weights_i, n_features_i;
    logic [RW-1:0]     rom_data;
    logic              ready_o, done_o, rst_o, load_o, start_op_o;
    logic              rd_rom, rd_w, rd_f;
    logic [AW-1:0]     rom_a, w_a, f_a;
    logic [NR*SW-1:0]  f_sel_o;
    logic [NR*CW-1:0]  ncol_o, row_num_o;
    logic [NC-1:0]     en_o;
`ifdef SA_SEQ_STALL_EN
    logic              stall_i = 1'b0;
`endif

    sa_sequencer dut (
        .clk_i               (clk),
        .general_rst_ni      (general_rst_ni),
        .start_i             (start_i),
        .filter_size_i       (filter_size_i),
        .n_tiles_i           (n_tiles_i),
        .n_weights_i         (n_weights_i),
        .n_features_i        (n_features_i),
`ifdef SA_SEQ_STALL_EN
        .stall_i             (stall_i),
`endif
        .rom_signals_data_i  (rom_data),
        .ready_o             (ready_o),
        .done_o              (done_o),
        .rst_o               (rst_o),
        .load_o              (load_o),
        .start_op_o          (start_op_o),
        .rd_rom_signals_ld_o (rd_rom),
        .addrs_rom_signal_o  (rom_a),
        .rd_weight_ld_o      (rd_w),
        .addrs_weight_o      (w_a),
        .rd_feature_ld_o     (rd_f),
        .addrs_mem_feature_o (f_a),
        .f_sel_o             (f_sel_o),
        .number_of_columns_o (ncol_o),
        .row_num_o           (row_num_o),
        .en_adder_node_o     (en_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit ready, done, rst, load, sop, rrom, rw, rf, cfg;
        int rom_a, w_a, f_a, tile, fs;
    } exp_t;

    exp_t        q[$];
    int          vectors = 0;
    int          miscompares = 0;
    bit          cmp_en = 1'b0;
    logic [RW-1:0] rom_mem [0:7];
    int          done_at;
    logic [NC-1:0]    cap_en;
    logic [NR*CW-1:0] cap_rn;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t blank();
        exp_t e;
        e.ready = 0; e.done = 0; e.rst = 0; e.load = 0; e.sop = 0;
        e.rrom = 0; e.rw = 0; e.rf = 0; e.cfg = 0;
        e.rom_a = 0; e.w_a = 0; e.f_a = 0; e.tile = 0; e.fs = 1;
        return e;
    endfunction

    // Synchronous ROM with 1-cycle read latency; zero when not read
    always @(posedge clk) begin
        if (rd_rom) rom_data <= rom_mem[rom_a[2:0]];
        else        rom_data <= '0;
    end

    // Expected per-cycle timeline of one job, starting with the cycle before the start edge
    task automatic build_job(input int fs, input int nt, input int w, input int f);
        exp_t e;
        int   wa;
        e = blank(); e.ready = 1; q.push_back(e);
        if (fs == 0 || nt == 0) begin
            e = blank(); e.ready = 1; e.done = 1; q.push_back(e);
            return;
        end
        wa = 0;
        for (int t = 0; t < nt; t++) begin
            e = blank(); e.rst = 1; q.push_back(e);
            e = blank(); e.rrom = 1; e.rom_a = t; q.push_back(e);
            e = blank(); q.push_back(e);
            for (int i = 0; i < (w == 0 ? 1 : w); i++) begin
                e = blank(); e.cfg = 1; e.tile = t; e.fs = fs;
                if (w != 0) begin e.load = 1; e.rw = 1; e.w_a = wa % 1024; wa++; end
                q.push_back(e);
            end
            for (int i = 0; i < (f == 0 ? 1 : f); i++) begin
                e = blank(); e.cfg = 1; e.tile = t; e.fs = fs;
                if (f != 0) begin e.sop = 1; e.rf = 1; e.f_a = i % 1024; end
                q.push_back(e);
            end
        end
        e = blank(); e.done = 1; q.push_back(e);
    endtask

    // Compare process: every cycle against the model timeline (idle when empty)
    always @(negedge clk) begin : cmp
        exp_t e;
        logic [NC-1:0]    ee;
        logic [NR*CW-1:0] rn;
        if (cmp_en) begin
            if (q.size() > 0) e = q.pop_front();
            else begin e = blank(); e.ready = 1; end
            chk("ready", 32'(ready_o), 32'(e.ready));
            chk("done", 32'(done_o), 32'(e.done));
            chk("rst", 32'(rst_o), 32'(e.rst));
            chk("load", 32'(load_o), 32'(e.load));
            chk("start_op", 32'(start_op_o), 32'(e.sop));
            chk("rd_rom", 32'(rd_rom), 32'(e.rrom));
            chk("rd_weight", 32'(rd_w), 32'(e.rw));
            chk("rd_feature", 32'(rd_f), 32'(e.rf));
            if (e.rrom) chk("rom_addr", 32'(rom_a), e.rom_a);
            if (e.rw)   chk("weight_addr", 32'(w_a), e.w_a);
            if (e.rf)   chk("feature_addr", 32'(f_a), e.f_a);
            if (e.cfg) begin
                for (int c = 0; c < NC; c++) ee[c] = (c < int'(rom_mem[e.tile][9:8]));
                for (int j = 0; j < NR; j++) rn[j*CW +: CW] = CW'((j % e.fs) + 1);
                chk("f_sel", 32'(f_sel_o), 32'(rom_mem[e.tile][7:0]));
                chk("ncols", 32'(ncol_o), 32'(rom_mem[e.tile][15:8]));
                chk("en_adder", 32'(en_o), 32'(ee));
                chk("row_num", 32'(row_num_o), 32'(rn));
            end
        end
    end

    task automatic start_job(input int fs, input int nt, input int w, input int f);
        @(posedge clk); #1;
        filter_size_i = CW'(fs); n_tiles_i = CNT'(nt);
        n_weights_i = CNT'(w); n_features_i = CNT'(f);
        start_i = 1'b1;
        build_job(fs, nt, w, f);
        @(posedge clk); #1;
        start_i = 1'b0;
        filter_size_i = CW'($urandom); n_tiles_i = CNT'($urandom);
        n_weights_i = CNT'($urandom); n_features_i = CNT'($urandom);
    endtask

    // Run a job to completion, capturing done cycle and first LOAD-cycle config
    task automatic run_job(input int fs, input int nt, input int w, input int f);
        int cyc;
        int guard;
        start_job(fs, nt, w, f);
        cyc = 1; guard = 0; done_at = -1; cap_en = '0; cap_rn = '0;
        while (q.size() > 0 && guard < 5000) begin
            if (done_o && done_at < 0) done_at = cyc;
            if (load_o && cap_rn == '0) begin cap_en = en_o; cap_rn = row_num_o; end
            @(posedge clk); #1;
            cyc++; guard++;
        end
        chk("drain", 32'(q.size()), 0);
    endtask

    initial begin
        int g;
        rom_mem[0] = {84'(32'hDEADBEEF), 8'hD2, 8'h92};
        rom_mem[1] = {84'(32'h12345678), 8'h73, 8'h1B};
        rom_mem[2] = {84'(32'hCAFEF00D), 8'h01, 8'hE4};
        for (int k = 3; k < 8; k++) rom_mem[k] = {84'(k), 8'h00, 8'hFF};
        rom_data = '0;
        start_i = 0; filter_size_i = 0; n_tiles_i = 0; n_weights_i = 0; n_features_i = 0;
        general_rst_ni = 1'b0;

        repeat (2) @(posedge clk); #1;
        chk("rst_ready", 32'(ready_o), 1);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_strobes", 32'({rst_o, load_o, start_op_o, rd_rom, rd_w, rd_f}), 0);
        chk("rst_addrs", 32'({rom_a, w_a}), 0);
        chk("rst_faddr", 32'(f_a), 0);
        chk("rst_cfg", 32'({f_sel_o, ncol_o, row_num_o, en_o}), 0);
        general_rst_ni = 1'b1;
        cmp_en = 1'b1;
        repeat (5) @(posedge clk);

        run_job(3, 1, 4, 6);
        chk("single_done_cycle", done_at, 14);
        chk("single_row_num", 32'(cap_rn), 32'h79);
        chk("single_en", 32'(cap_en), 32'h3);

        run_job(2, 3, 2, 3);
        chk("three_done_cycle", done_at, 25);

        run_job(2, 0, 5, 5);
        chk("ntiles0_done_cycle", done_at, 1);
        run_job(0, 2, 5, 5);
        chk("fs0_done_cycle", done_at, 1);

        run_job(1, 2, 0, 2);
        chk("w0_done_cycle", done_at, 13);
        run_job(2, 1, 3, 0);
        chk("f0_done_cycle", done_at, 8);

        run_job(3, 1, 1030, 1);
        chk("wrap_done_cycle", done_at, 1035);

        // Abort in COMPUTE, then restart
        start_job(2, 2, 2, 4);
        g = 0;
        while (!start_op_o && g < 50) begin @(posedge clk); #1; g++; end
        chk("abort_reached_compute", 32'(start_op_o), 1);
        cmp_en = 1'b0;
        q.delete();
        general_rst_ni = 1'b0;
        #1;
        chk("abort_ready", 32'(ready_o), 1);
        chk("abort_sop", 32'(start_op_o), 0);
        chk("abort_rd_f", 32'(rd_f), 0);
        chk("abort_row_num", 32'(row_num_o), 0);
        @(posedge clk); #1;
        chk("abort_done", 32'(done_o), 0);
        general_rst_ni = 1'b1;
        @(posedge clk); #1;
        cmp_en = 1'b1;
        run_job(3, 1, 4, 6);
        chk("post_abort_done_cycle", done_at, 14);
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
